// File: rtl/actor_launch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// TriggerTypes: shared trigger types for the actor launch sequencer.
//   return_t : 32-bit code returned by an actor core on actor_done.
//   state_t  : sequencer FSM state, also exported on state_dbg.
//   mode_t   : launch policy (repeat until sleep vs. one execution per start).
//   SLEEP_THRESHOLD_DEFAULT : default number of non-productive returns /
//                             empty probe cycles tolerated before sleeping.
// ---------------------------------------------------------------------------
package TriggerTypes;

  typedef enum logic [31:0] {
    IDLE           = 32'd0,
    EXECUTED       = 32'd1,
    WAIT_INPUT     = 32'd2,
    WAIT_OUTPUT    = 32'd3,
    WAIT_GAURD     = 32'd4,
    WAIT_PREDICATE = 32'd5
  } return_t;

  typedef enum logic [2:0] {
    STAND_BY     = 3'd0,
    TRY_LAUNCH   = 3'd1,
    LAUNCH       = 3'd2,
    CHECK_RETURN = 3'd3,
    PROBE_INPUT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACTOR_TRIGGER  = 2'd0,
    INPUT_TRIGGER  = 2'd1,
    OUTPUT_TRIGGER = 2'd2
  } mode_t;

  localparam int unsigned SLEEP_THRESHOLD_DEFAULT = 32'd4;

endpackage

// File: rtl/actor_launch_sequencer_if.sv
// ---------------------------------------------------------------------------
// actor_launch_sequencer_if: bundle of the network control handshake, the
// actor-core ap_ctrl_hs handshake and the input FIFO probes.
//   master : network/actor side (drives start, actor responses, FIFO status)
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface actor_launch_sequencer_if #(
  parameter int unsigned NUM_INPUTS = 32'd2
) ();

  logic                  ap_start;
  logic                  ap_done;
  logic                  ap_idle;
  logic                  ap_ready;
  logic                  actor_start;
  logic                  actor_ready;
  logic                  actor_done;
  logic [31:0]           actor_return;
  logic [NUM_INPUTS-1:0] input_empty_n;

  modport master (
    output ap_start, actor_ready, actor_done, actor_return, input_empty_n,
    input  ap_done, ap_idle, ap_ready, actor_start
  );

  modport slave (
    input  ap_start, actor_ready, actor_done, actor_return, input_empty_n,
    output ap_done, ap_idle, ap_ready, actor_start
  );

endinterface

// File: rtl/actor_launch_sequencer_counter.sv
// ---------------------------------------------------------------------------
// trigger_threshold_counter: 8-bit saturating counter used for both the
// failed-return count and the empty-probe count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (wins over incr)
//   incr       : count one event; never counts past THRESHOLD
//   hit        : the next incr brings the count to THRESHOLD. It does not
//                depend on incr, so the caller's decode has no comb loop.
// ---------------------------------------------------------------------------
module trigger_threshold_counter
  import TriggerTypes::*;
#(
  parameter int unsigned THRESHOLD = SLEEP_THRESHOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic incr,
  output logic hit
);

  localparam logic [7:0] LIMIT = 8'(THRESHOLD);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    hit     = (count_q >= (LIMIT - 8'd1));
    if (clear) begin
      count_d = 8'd0;
    end else if (incr) begin
      if (count_q < LIMIT) begin
        count_d = count_q + 8'd1;
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/actor_launch_sequencer.sv
// ---------------------------------------------------------------------------
// actor_launch_sequencer: launches an HLS actor core (ap_ctrl_hs) on request
// of the network and keeps relaunching it until it stops being productive.
//   ap_clk, ap_rst_n          : clock, asynchronous active-low reset
//   ap_start                  : network run request (sampled in STAND_BY only)
//   ap_done / ap_ready        : one-cycle pulse on the first STAND_BY cycle
//   ap_idle                   : high while in STAND_BY
//   actor_start/ready/done    : handshake to the actor core
//   actor_return              : return code, valid with actor_done
//   input_empty_n             : per-input FIFO not-empty, probed on WAIT_INPUT
//   exec_count                : number of EXECUTED returns (wraps)
//   state_dbg                 : current FSM state
// ---------------------------------------------------------------------------
module actor_launch_sequencer
  import TriggerTypes::*;
#(
  parameter mode_t       MODE            = ACTOR_TRIGGER,
  parameter int unsigned NUM_INPUTS      = 32'd2,
  parameter int unsigned SLEEP_THRESHOLD = SLEEP_THRESHOLD_DEFAULT,
  parameter int unsigned CNT_W           = 32'd32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  actor_start,
  input  logic                  actor_ready,
  input  logic                  actor_done,
  input  logic [31:0]           actor_return,
  input  logic [NUM_INPUTS-1:0] input_empty_n,
  output logic [CNT_W-1:0]      exec_count,
  output logic [2:0]            state_dbg
);

  state_t             state_q, state_d;
  logic [31:0]        ret_q, ret_d;
  logic [CNT_W-1:0]   exec_q, exec_d;
  logic               done_q, done_d;

  logic fail_clr, fail_inc, fail_hit;
  logic probe_clr, probe_inc, probe_hit;

  trigger_threshold_counter #(.THRESHOLD(SLEEP_THRESHOLD)) u_fail_cnt (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .clear (fail_clr),
    .incr  (fail_inc),
    .hit   (fail_hit)
  );

  trigger_threshold_counter #(.THRESHOLD(SLEEP_THRESHOLD)) u_probe_cnt (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .clear (probe_clr),
    .incr  (probe_inc),
    .hit   (probe_hit)
  );

  // Next-state, return latch, execution count and counter controls.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    exec_d      = exec_q;
    fail_clr    = 1'b0;
    fail_inc    = 1'b0;
    probe_clr   = 1'b0;
    probe_inc   = 1'b0;
    actor_start = 1'b0;
    case (state_q)
      STAND_BY: begin
        if (ap_start) begin
          state_d   = TRY_LAUNCH;
          fail_clr  = 1'b1;
          probe_clr = 1'b1;
        end else begin
          state_d = STAND_BY;
        end
      end
      TRY_LAUNCH: begin
        actor_start = 1'b1;
        if (actor_ready) begin
          // A core may accept and finish in the same cycle; skip LAUNCH then.
          if (actor_done) begin
            ret_d   = actor_return;
            state_d = CHECK_RETURN;
          end else begin
            state_d = LAUNCH;
          end
        end else begin
          state_d = TRY_LAUNCH;
        end
      end
      LAUNCH: begin
        if (actor_done) begin
          ret_d   = actor_return;
          state_d = CHECK_RETURN;
        end else begin
          state_d = LAUNCH;
        end
      end
      CHECK_RETURN: begin
        if (ret_q == EXECUTED) begin
          exec_d   = exec_q + CNT_W'(1);
          fail_clr = 1'b1;
          if (MODE == ACTOR_TRIGGER) begin
            state_d = TRY_LAUNCH;
          end else begin
            state_d = STAND_BY;
          end
        end else if (ret_q == WAIT_INPUT) begin
          probe_clr = 1'b1;
          state_d   = PROBE_INPUT;
        end else begin
          // Every other code, including undefined ones, is non-productive.
          fail_inc = 1'b1;
          if (fail_hit) begin
            state_d = STAND_BY;
          end else begin
            state_d = TRY_LAUNCH;
          end
        end
      end
      PROBE_INPUT: begin
        if (|input_empty_n) begin
          state_d = TRY_LAUNCH;
        end else begin
          probe_inc = 1'b1;
          if (probe_hit) begin
            state_d = STAND_BY;
          end else begin
            state_d = PROBE_INPUT;
          end
        end
      end
      default: begin
        state_d = STAND_BY;
      end
    endcase
    // Done pulse marks the first cycle back in STAND_BY.
    done_d = (state_d == STAND_BY) && (state_q != STAND_BY);
  end

  // Sequencer state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= STAND_BY;
      ret_q   <= IDLE;
      exec_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      exec_q  <= exec_d;
      done_q  <= done_d;
    end
  end

  assign ap_done    = done_q;
  assign ap_ready   = done_q;
  assign ap_idle    = (state_q == STAND_BY);
  assign exec_count = exec_q;
  assign state_dbg  = state_q;

endmodule

// File: doc/actor_launch_sequencer.md
ACTOR_LAUNCH_SEQUENCER -- requirements
Module: actor_launch_sequencer

Interface
REQ-001 Parameters SHALL be:
- MODE, ACTOR_TRIGGER, TriggerTypes::mode_t; repeat launches until sleep (ACTOR_TRIGGER) or one successful execution per start (INPUT_TRIGGER/OUTPUT_TRIGGER).
- NUM_INPUTS, 2, number of probed input FIFOs.
- SLEEP_THRESHOLD, 4, consecutive non-productive returns or empty-probe cycles before sleep; legal range 1..255.
- CNT_W, 32, execution counter width.
REQ-002 Ports SHALL be:
- ap_clk  in  1  clock; one clock domain.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  network request to run.
- ap_done  out  1  one-cycle pulse when the sequencer returns to sleep.
- ap_idle  out  1  high while in STAND_BY.
- ap_ready  out  1  identical to ap_done.
- actor_start  out  1  HLS ap_ctrl_hs start to the actor core.
- actor_ready  in  1  actor accepted start.
- actor_done  in  1  actor finished; actor_return is valid this cycle.
- actor_return  in  32  TriggerTypes::return_t code.
- input_empty_n  in  NUM_INPUTS  per-input FIFO not-empty.
- exec_count  out  CNT_W  count of EXECUTED returns.
- state_dbg  out  3  current TriggerTypes::state_t.

Function
REQ-003 The FSM SHALL use the states STAND_BY, TRY_LAUNCH, LAUNCH, CHECK_RETURN and PROBE_INPUT from TriggerTypes::state_t.
REQ-004 In STAND_BY, ap_start=1 SHALL move the FSM to TRY_LAUNCH next cycle and clear fail_cnt and probe_cnt.
- ap_start is ignored in every other state.
REQ-005 TRY_LAUNCH SHALL assert actor_start combinationally and hold it until actor_ready=1.
- actor_ready=1 with actor_done=0: go to LAUNCH.
- actor_ready=1 with actor_done=1 in the same cycle: latch actor_return and go directly to CHECK_RETURN.
REQ-006 LAUNCH SHALL deassert actor_start and wait for actor_done=1, then latch actor_return and go to CHECK_RETURN.
- LAUNCH has no timeout.
REQ-007 CHECK_RETURN SHALL take exactly one cycle and decode the latched code as follows:
- EXECUTED: exec_count+1 and fail_cnt cleared.
  - ACTOR_TRIGGER: go to TRY_LAUNCH.
  - Other modes: go to STAND_BY with ap_done.
- WAIT_INPUT: clear probe_cnt and go to PROBE_INPUT.
- WAIT_OUTPUT, WAIT_GAURD, WAIT_PREDICATE, IDLE, or any undefined code: fail_cnt+1.
  - If the new value equals SLEEP_THRESHOLD: go to STAND_BY with ap_done.
  - Otherwise: go to TRY_LAUNCH.
REQ-008 PROBE_INPUT SHALL check input_empty_n every cycle.
- Any bit=1: go to TRY_LAUNCH; fail_cnt is unchanged.
- All bits=0: probe_cnt+1. If the new value equals SLEEP_THRESHOLD: go to STAND_BY with ap_done.
REQ-009 ap_done and ap_ready SHALL be registered pulses, high exactly on the first cycle back in STAND_BY.
REQ-010 ap_idle SHALL equal (state==STAND_BY).
REQ-011 exec_count SHALL wrap modulo 2^CNT_W and SHALL NOT be cleared by ap_start.
REQ-012 fail_cnt and probe_cnt SHALL be 8 bits wide and SHALL never exceed SLEEP_THRESHOLD.
REQ-013 state_dbg SHALL equal the encoded current state.

Reset
REQ-014 ap_rst_n=0 SHALL, asynchronously and from any state (including mid-launch), force:
- state to STAND_BY;
- actor_start=0, ap_done=0, ap_ready=0, ap_idle=1;
- exec_count=0, fail_cnt=0, probe_cnt=0, latched return=IDLE.
REQ-015 Reset release SHALL take effect only at an ap_clk edge, and the first launch SHALL require a fresh ap_start.

Structure
REQ-016 return_t, state_t and mode_t SHALL come from the shared TriggerTypes package.
- A new constant SLEEP_THRESHOLD_DEFAULT=4 SHALL be added to that package.
- No types SHALL be declared locally.
REQ-017 The two saturating threshold counters (fail_cnt, probe_cnt) SHALL be one reusable sub-module, trigger_threshold_counter, with ports clear, incr and hit.

Verification
REQ-018 ap_start pulse with the actor returning EXECUTED three times, then WAIT_OUTPUT four times (ACTOR_TRIGGER, threshold 4) -> exec_count=3, exactly 7 actor_start handshakes, one ap_done pulse, ap_idle=1.
REQ-019 WAIT_INPUT return with input_empty_n=2'b00 for 2 cycles then 2'b10 -> PROBE_INPUT for 3 cycles, then TRY_LAUNCH with no ap_done.
REQ-020 WAIT_INPUT return with input_empty_n held at 0 -> ap_done exactly 4 cycles after entering PROBE_INPUT.
REQ-021 actor_ready and actor_done in the same cycle with EXECUTED, MODE=INPUT_TRIGGER -> LAUNCH skipped, exec_count=1, ap_done pulse, return to STAND_BY.
REQ-022 ap_rst_n asserted while in LAUNCH, and ap_start pulsed while in LAUNCH -> actor_start=0 and ap_idle=1 immediately with no clock edge; exec_count=0; the mid-run ap_start is ignored.
REQ-023 actor_return=32'h0000_00FF -> treated as non-productive, fail_cnt+1, relaunch.
